full_adder: RTL and testbench

Parameterizable ripple-carry adder built from 1-bit full-adder cells, with a combinational result path and a one-cycle registered result path. It serves as the basic arithmetic primitive for datapaths that need either an immediate sum or a pipelined, valid-qualified sum. With the default WIDTH of 1 it is a plain 1-bit full adder: a, b and carry-in c produce sum and carry.

---
 rtl/full_adder.sv | 117 +++++++++++
 tb/tb_full_adder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
// Parameterizable ripple-carry adder built from 1-bit full-adder cells.
// It provides an immediate combinational result and a one-cycle registered
// result that is qualified by a valid flag. It also keeps a sticky record of
// carry-outs.
//
// Optional feature macro: FULL_ADDER_OVF_EN
//   When defined, the block adds the ovf_q port, which holds the registered
//   two's-complement overflow.
//
// Ports
//   clk          in   rising-edge clock for the registered path and sticky flag
//   rst_n        in   asynchronous active-low reset
//   a, b         in   WIDTH-bit unsigned operands
//   c            in   carry-in
//   in_valid     in   qualifies a/b/c for capture by the registered path
//   clr_sticky   in   synchronous clear of carry_sticky (a same-edge set wins)
//   sum          out  combinational a + b + c, low WIDTH bits
//   carry        out  combinational carry-out of the MSB cell
//   sum_q        out  registered sum
//   carry_q      out  registered carry-out
//   out_valid    out  sum_q/carry_q were captured on the previous edge
//   carry_sticky out  set by any captured carry-out, held until cleared
//   ovf_q        out  registered signed overflow (FULL_ADDER_OVF_EN only)
// ----------------------------------------------------------------------------
module full_adder #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic             in_valid,
  input  logic             clr_sticky,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic [WIDTH-1:0] sum_q,
  output logic             carry_q,
  output logic             out_valid,
`ifdef FULL_ADDER_OVF_EN
  output logic             carry_sticky,
  output logic             ovf_q
`else
  output logic             carry_sticky
`endif
);

  // w_k[i] is the carry into cell i; w_k[0] is the external carry-in.
  logic [WIDTH:0]   w_k;
  logic [WIDTH-1:0] w_s;

  logic [WIDTH-1:0] r_sum_q;
  logic             r_carry_q;
  logic             r_out_valid;
  logic             r_carry_sticky;

  assign w_k[0] = c;

  // Ripple chain of 1-bit full-adder cells.
  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_cell
    assign w_s[i]   = a[i] ^ b[i] ^ w_k[i];
    assign w_k[i+1] = (a[i] & b[i]) | (a[i] & w_k[i]) | (b[i] & w_k[i]);
  end

  assign sum   = w_s;
  assign carry = w_k[WIDTH];

  // Result capture: hold on in_valid=0, valid flag follows in_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q     <= '0;
      r_carry_q   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_sum_q   <= w_s;
        r_carry_q <= w_k[WIDTH];
      end
    end
  end

  // Sticky carry: a captured carry overrides a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_sticky <= 1'b0;
    end else if (in_valid && w_k[WIDTH]) begin
      r_carry_sticky <= 1'b1;
    end else if (clr_sticky) begin
      r_carry_sticky <= 1'b0;
    end
  end

  assign sum_q        = r_sum_q;
  assign carry_q      = r_carry_q;
  assign out_valid    = r_out_valid;
  assign carry_sticky = r_carry_sticky;

`ifdef FULL_ADDER_OVF_EN
  logic r_ovf_q;

  // Signed overflow: the carries into and out of the MSB cell disagree.
  // For WIDTH=1 the carry into the MSB cell is the carry-in c.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_q <= 1'b0;
    end else if (in_valid) begin
      r_ovf_q <= w_k[WIDTH] ^ w_k[WIDTH-1];
    end
  end

  assign ovf_q = r_ovf_q;
`endif

endmodule

// File: tb/tb_full_adder.sv
// ----------------------------------------------------------------------------
// tb_full_adder
// Self-checking bench. It drives one 1-bit instance and one 8-bit instance of
// full_adder and checks them against integer-arithmetic expectations and a
// small cycle model of the registered path.
// ----------------------------------------------------------------------------
module tb_full_adder;

  logic clk;
  logic rst_n;

  // 1-bit instance
  logic a1, b1, c1;
  logic sum1, carry1, sum_q1, carry_q1, out_valid1, sticky1;

  // 8-bit instance
  logic [7:0] a8, b8;
  logic       c8, iv8, clr8;
  logic [7:0] sum8, sum_q8;
  logic       carry8, carry_q8, out_valid8, sticky8;
`ifdef FULL_ADDER_OVF_EN
  logic       ovf1, ovf8;
`endif

  int n_checks;
  int n_fail;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a1),
    .b            (b1),
    .c            (c1),
    .in_valid     (1'b0),
    .clr_sticky   (1'b0),
    .sum          (sum1),
    .carry        (carry1),
    .sum_q        (sum_q1),
    .carry_q      (carry_q1),
    .out_valid    (out_valid1),
`ifdef FULL_ADDER_OVF_EN
    .carry_sticky (sticky1),
    .ovf_q        (ovf1)
`else
    .carry_sticky (sticky1)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .a            (a8),
    .b            (b8),
    .c            (c8),
    .in_valid     (iv8),
    .clr_sticky   (clr8),
    .sum          (sum8),
    .carry        (carry8),
    .sum_q        (sum_q8),
    .carry_q      (carry_q8),
    .out_valid    (out_valid8),
`ifdef FULL_ADDER_OVF_EN
    .carry_sticky (sticky8),
    .ovf_q        (ovf8)
`else
    .carry_sticky (sticky8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] exp1 [8];
    logic [8:0] tot;
    int         sres;
    logic [7:0] m_sum_q;
    logic       m_carry_q, m_ov, m_sticky, m_ovf;
    logic [2:0] v;

    n_checks = 0;
    n_fail   = 0;
    // {carry,sum} for {a,b,c} = 0..7
    exp1[0] = 2'b00; exp1[1] = 2'b01; exp1[2] = 2'b01; exp1[3] = 2'b10;
    exp1[4] = 2'b01; exp1[5] = 2'b10; exp1[6] = 2'b10; exp1[7] = 2'b11;

    rst_n = 1'b0;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    a8 = 8'h00; b8 = 8'h00; c8 = 1'b0; iv8 = 1'b0; clr8 = 1'b0;
    #3;
    chk("rst_sum_q",     64'(sum_q8),     64'h0);
    chk("rst_carry_q",   64'(carry_q8),   64'h0);
    chk("rst_out_valid", 64'(out_valid8), 64'h0);
    chk("rst_sticky",    64'(sticky8),    64'h0);
`ifdef FULL_ADDER_OVF_EN
    chk("rst_ovf",       64'(ovf8),       64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 truth table sweep
    for (int i = 0; i < 8; i++) begin
      v  = 3'(i);
      a1 = v[2]; b1 = v[1]; c1 = v[0];
      #1;
      chk($sformatf("w1_sum_%0d", i),   64'(sum1),   64'(exp1[i][0]));
      chk($sformatf("w1_carry_%0d", i), 64'(carry1), 64'(exp1[i][1]));
    end
    chk("w1_out_valid_idle", 64'(out_valid1), 64'h0);

    // All-ones wrap
    a8 = 8'hFF; b8 = 8'h00; c8 = 1'b1; iv8 = 1'b1;
    #1;
    chk("wrap_sum",   64'(sum8),   64'h00);
    chk("wrap_carry", 64'(carry8), 64'h1);
    step();
    chk("wrap_sum_q",     64'(sum_q8),     64'h00);
    chk("wrap_carry_q",   64'(carry_q8),   64'h1);
    chk("wrap_out_valid", 64'(out_valid8), 64'h1);
    chk("wrap_sticky",    64'(sticky8),    64'h1);
    iv8 = 1'b0; a8 = 8'h55; b8 = 8'h11; c8 = 1'b0;
    step();
    chk("hold_out_valid", 64'(out_valid8), 64'h0);
    chk("hold_sum_q",     64'(sum_q8),     64'h00);
    chk("hold_carry_q",   64'(carry_q8),   64'h1);

    // Sticky clear with no capture
    clr8 = 1'b1;
    step();
    chk("clr_sticky", 64'(sticky8), 64'h0);
    clr8 = 1'b0;

    // Back-to-back captures
    iv8 = 1'b1; a8 = 8'h12; b8 = 8'h34; c8 = 1'b0;
    step();
    chk("b2b1_sum_q",     64'(sum_q8),     64'h46);
    chk("b2b1_carry_q",   64'(carry_q8),   64'h0);
    chk("b2b1_out_valid", 64'(out_valid8), 64'h1);
    chk("b2b1_sticky",    64'(sticky8),    64'h0);
    a8 = 8'h80; b8 = 8'h80;
    step();
    chk("b2b2_sum_q",     64'(sum_q8),     64'h00);
    chk("b2b2_carry_q",   64'(carry_q8),   64'h1);
    chk("b2b2_out_valid", 64'(out_valid8), 64'h1);
    chk("b2b2_sticky",    64'(sticky8),    64'h1);

    // Set beats clear on the same edge; then clear with a carry-free capture
    clr8 = 1'b1;
    step();
    chk("prio_sticky", 64'(sticky8), 64'h1);
    a8 = 8'h01; b8 = 8'h01;
    step();
    chk("clr_on_capture_sticky", 64'(sticky8), 64'h0);
    clr8 = 1'b0;

`ifdef FULL_ADDER_OVF_EN
    a8 = 8'h7F; b8 = 8'h01; c8 = 1'b0;
    step();
    chk("ovf_pos", 64'(ovf8), 64'h1);
    a8 = 8'hFF; b8 = 8'h01;
    step();
    chk("ovf_neg_ovf",   64'(ovf8),     64'h0);
    chk("ovf_neg_carry", 64'(carry_q8), 64'h1);
    iv8 = 1'b0;
    step();
    chk("ovf_hold", 64'(ovf8), 64'h0);
    iv8 = 1'b1;
`endif

    // Reset mid-stream
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; iv8 = 1'b1;
    step();
    chk("pre_rst_out_valid", 64'(out_valid8), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_sum_q",     64'(sum_q8),     64'h0);
    chk("mid_rst_carry_q",   64'(carry_q8),   64'h0);
    chk("mid_rst_out_valid", 64'(out_valid8), 64'h0);
    chk("mid_rst_sticky",    64'(sticky8),    64'h0);
    a8 = 8'h05; b8 = 8'h03; c8 = 1'b0;
    #1;
    chk("rst_comb_sum",   64'(sum8),   64'h08);
    chk("rst_comb_carry", 64'(carry8), 64'h0);
    @(negedge clk);
    chk("rst_hold_out_valid", 64'(out_valid8), 64'h0);
    iv8 = 1'b0;
    rst_n = 1'b1;

    // Randomized traffic against a cycle model
    m_sum_q = 8'h00; m_carry_q = 1'b0; m_ov = 1'b0; m_sticky = 1'b0; m_ovf = 1'b0;
    for (int n = 0; n < 300; n++) begin
      a8   = 8'($urandom);
      b8   = 8'($urandom);
      c8   = 1'($urandom);
      iv8  = ($urandom_range(0, 3) != 0);
      clr8 = ($urandom_range(0, 7) == 0);
      tot  = 9'(a8) + 9'(b8) + 9'(c8);
      sres = int'($signed(a8)) + int'($signed(b8)) + int'(c8);
      #1;
      chk("rnd_sum",   64'(sum8),   64'(tot[7:0]));
      chk("rnd_carry", 64'(carry8), 64'(tot[8]));
      m_ov = iv8;
      if (iv8) begin
        m_sum_q   = tot[7:0];
        m_carry_q = tot[8];
        m_ovf     = (sres > 127) || (sres < -128);
      end
      if (iv8 && tot[8]) m_sticky = 1'b1;
      else if (clr8)     m_sticky = 1'b0;
      step();
      chk("rnd_sum_q",     64'(sum_q8),     64'(m_sum_q));
      chk("rnd_carry_q",   64'(carry_q8),   64'(m_carry_q));
      chk("rnd_out_valid", 64'(out_valid8), 64'(m_ov));
      chk("rnd_sticky",    64'(sticky8),    64'(m_sticky));
`ifdef FULL_ADDER_OVF_EN
      chk("rnd_ovf",       64'(ovf8),       64'(m_ovf));
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
